// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Small byte FIFO. Full and empty come from a separate occupancy count.
// A push on a full FIFO is still taken when a pop happens in the same cycle.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; reset only clears the pointers, so the stale contents are never read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/uart_send_tx.sv
// Transmit end of the core's UART send handshake: captures request bytes into a
// FIFO with a one-cycle ack, then serialises them on txd as 8N1 frames, LSB first.
module uart_send_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] uart_send_data,
    input  logic       uart_send_ready,
    output logic       uart_send_valid,
    output logic       txd,
    output logic       busy
);

    localparam int            BW        = $clog2(CLKS_PER_BIT);
    localparam int            IW        = $clog2(DATA_BITS);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);

    tx_state_t     state;
    tx_state_t     state_n;
    logic [BW-1:0] baud_cnt;
    logic [BW-1:0] baud_n;
    logic [IW-1:0] bit_idx;
    logic [IW-1:0] bit_n;
    logic [7:0]    sh;
    logic [7:0]    sh_n;
    logic          txd_n;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_dout;
    logic          accept;

    // The previous-cycle ack blocks a second capture of the same held request;
    // a pop in the same cycle frees a slot in an otherwise full FIFO.
    assign accept = uart_send_ready && !uart_send_valid && (!fifo_full || fifo_pop);

    byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (accept),
        .din  (uart_send_data),
        .pop  (fifo_pop),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    // Next-state logic; txd_n is derived from the next state so txd can be a plain register.
    always_comb begin
        state_n  = state;
        baud_n   = baud_cnt;
        bit_n    = bit_idx;
        sh_n     = sh;
        fifo_pop = 1'b0;
        txd_n    = 1'b1;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    sh_n     = fifo_dout;
                    baud_n   = '0;
                    bit_n    = '0;
                    state_n  = START;
                end
            end
            START: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = DATA;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_n = '0;
                    if (bit_idx == LAST_BIT) begin
                        state_n = STOP;
                    end else begin
                        sh_n  = {1'b0, sh[7:1]};
                        bit_n = bit_idx + 1'b1;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_n  = '0;
                    state_n = IDLE;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = sh_n[0];
            default: txd_n = 1'b1;
        endcase
    end

    // State, datapath and registered outputs; reset drops any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            baud_cnt        <= '0;
            bit_idx         <= '0;
            sh              <= '0;
            txd             <= 1'b1;
            uart_send_valid <= 1'b0;
            busy            <= 1'b0;
        end else begin
            state           <= state_n;
            baud_cnt        <= baud_n;
            bit_idx         <= bit_n;
            sh              <= sh_n;
            txd             <= txd_n;
            uart_send_valid <= accept;
            busy            <= !fifo_empty || (state != IDLE);
        end
    end

endmodule
